// File: rtl/serial_pkg.sv
// Shared definitions for the serial IO device (transmit and receive paths).
// Holds the transmitter FSM state type, the default bit period and the data width.
// No ports; imported by baud_tick_gen and uart_tx.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // 100 MHz core clock / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned UART_DATA_BITS       = 8;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period wrap counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Ports: clk, rst (sync, active-high), clear (forces count to 0 on the next edge),
//        tick (combinational, high while count == CLKS_PER_BIT-1).
module baud_tick_gen
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned            CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]       LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, shifted out LSB first on txd.
// Ports: clk, rst (sync, active-high), tx_data/tx_valid/tx_ready byte handshake,
//        txd serial line (idle high), busy (frame in progress). All outputs registered.
module uart_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      txd,
    output logic                      busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t            state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      txd_q, txd_d;
    logic                      tx_ready_q, tx_ready_d;
    logic                      busy_q, busy_d;
    logic                      tick;
    logic                      accept;

    // Holding the counter cleared while idle makes the first bit period start
    // exactly at the accept edge, so every bit is a full CLKS_PER_BIT long.
    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    assign accept = (state_q == IDLE) && tx_valid && tx_ready_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        txd_d      = txd_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;

        unique case (state_q)
            IDLE: begin
                txd_d      = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (accept) begin
                    state_d    = START;
                    shift_d    = tx_data;
                    bit_idx_d  = '0;
                    txd_d      = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // Registered txd must already show the bit that the shift exposes.
                        txd_d = shift_q[1];
                    end
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (tick) begin
                    state_d    = IDLE;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign txd      = txd_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT = 4 and a CLKS_PER_BIT = 2 corner instance.
// Expected line levels come from the 8N1 frame definition: slot 0 start, slots 1..8 data LSB first, slot 9 stop.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       sel2;

    logic       valid4, ready4, txd4, busy4;
    logic       valid2, ready2, txd2, busy2;
    logic       ready_o, txd_o, busy_o;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    assign valid4  = tx_valid & ~sel2;
    assign valid2  = tx_valid & sel2;
    assign ready_o = sel2 ? ready2 : ready4;
    assign txd_o   = sel2 ? txd2   : txd4;
    assign busy_o  = sel2 ? busy2  : busy4;

    uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(valid4),
        .tx_ready(ready4),
        .txd     (txd4),
        .busy    (busy4)
    );

    uart_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(valid2),
        .tx_ready(ready2),
        .txd     (txd2),
        .busy    (busy2)
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Line level expected in a given bit slot of an 8N1 frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return 1'((b >> (slot - 1)) & 8'd1);
    endfunction

    int last_accept = 0;

    // mode 0: drop valid after accept; 1: keep valid high with next byte queued;
    // 2: scramble tx_data/tx_valid while the frame is in flight.
    task automatic run_frame(input logic [7:0] b, input int mode, input logic [7:0] nxt);
        int n;
        int guard;
        n = sel2 ? 2 : 4;
        guard = 0;
        while (ready_o !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) begin
            chk("ready_timeout", 32'(ready_o), 32'd1);
            return;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        last_accept = cycle;
        chk("acc_ready", 32'(ready_o), 32'd0);
        chk("acc_busy", 32'(busy_o), 32'd1);
        if (mode == 0) tx_valid = 1'b0;
        if (mode == 1) tx_data = nxt;
        for (int t = 0; t < 10 * n; t++) begin
            chk($sformatf("txd_%02h_slot%0d", b, t / n), 32'(txd_o), 32'(frame_bit(b, t / n)));
            if (t < 10 * n - 1) begin
                chk("busy_mid", 32'(busy_o), 32'd1);
            end
            if (mode == 2) begin
                tx_data  = 8'($urandom);
                tx_valid = 1'($urandom);
            end
            step();
        end
        if (mode == 2) tx_valid = 1'b0;
        chk("end_ready", 32'(ready_o), 32'd1);
        chk("end_busy", 32'(busy_o), 32'd0);
        chk("end_txd", 32'(txd_o), 32'd1);
    endtask

    initial begin
        int   first_acc;
        logic [7:0] rb;

        sel2     = 1'b0;
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;

        // Reset held three cycles with valid high: line idle, not ready, nothing starts.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_txd", 32'(txd_o), 32'd1);
            chk("rst_ready", 32'(ready_o), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
        end
        rst = 1'b0;
        step();
        chk("rel_ready", 32'(ready_o), 32'd1);
        chk("rel_txd", 32'(txd_o), 32'd1);
        first_acc = cycle + 1;

        // Single byte 0xA5, accepted on the very next edge.
        run_frame(8'hA5, 0, 8'h00);
        chk("rel_accept_edge", 32'(last_accept), 32'(first_acc));

        // Back-to-back 0x00 then 0xFF with valid held high.
        run_frame(8'h00, 1, 8'hFF);
        first_acc = last_accept;
        run_frame(8'hFF, 0, 8'h00);
        chk("b2b_period", 32'(last_accept - first_acc), 32'd41);

        // Data hold with noisy inputs while busy: wire must carry 0x81.
        step();
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        step();
        // Accept happened on this edge; change data one cycle later.
        tx_valid = 1'b0;
        step();
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        for (int t = 1; t < 40; t++) begin
            chk($sformatf("hold_slot%0d", t / 4), 32'(txd_o), 32'(frame_bit(8'h81, t / 4)));
            tx_valid = ~tx_valid;
            step();
        end
        tx_valid = 1'b0;
        chk("hold_end_ready", 32'(ready_o), 32'd1);
        step();
        chk("hold_no_accept", 32'(busy_o), 32'd0);

        // Random bytes, some with scrambled inputs during the frame.
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            run_frame(rb, (i % 2 == 0) ? 2 : 0, 8'h00);
            step();
        end

        // Mid-frame reset during data bit 3.
        tx_data  = 8'hC8;
        tx_valid = 1'b1;
        step();
        first_acc = cycle;
        tx_valid = 1'b0;
        for (int i = 0; i < 17; i++) step();
        chk("mid_bit3", 32'(txd_o), 32'(frame_bit(8'hC8, 4)));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_edge", 32'(cycle - first_acc), 32'd18);
        chk("mid_rst_txd", 32'(txd_o), 32'd1);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        step();
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        chk("mid_rst_txd2", 32'(txd_o), 32'd1);
        run_frame(8'h55, 0, 8'h00);

        // CLKS_PER_BIT = 2 corner: 0x01 in 20 cycles, two cycles per bit.
        sel2 = 1'b1;
        step();
        run_frame(8'h01, 0, 8'h00);
        rb = 8'($urandom);
        run_frame(rb, 0, 8'h00);
        sel2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the serial IO device: accepts one byte per valid/ready handshake from the CPU-side bus interface and shifts it out on `txd` as an 8N1 frame (1 start bit, 8 data bits LSB first, 1 stop bit, no parity). It is the transmit-direction counterpart of the serial receive path and uses the same bit-period convention, `CLKS_PER_BIT` clock cycles per bit. The block is fully synchronous with a single clock domain; `txd` goes directly to the board pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range 2..65535.
- `clk`  input  1  system clock
- `rst`  input  1  reset: `rst`, synchronous, active-high; clock `clk`
- `tx_data`  input  8  byte to send; sampled only on the accept edge
- `tx_valid`  input  1  producer has a byte on `tx_data`
- `tx_ready`  output  1  transmitter idle and able to accept; registered
- `txd`  output  1  serial line; idle/mark = 1; registered
- `busy`  output  1  frame in progress (start, data or stop bit); registered

## Operation
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on accept.
  - START -> DATA after one bit period.
  - DATA -> STOP after the 8th bit period.
  - STOP -> IDLE after one bit period.
- Accept occurs when `tx_valid && tx_ready` is sampled at a rising edge. On that edge:
  - the shift register loads `tx_data`;
  - `txd` is driven to 0;
  - `tx_ready` is driven to 0 and `busy` to 1;
  - the baud counter and bit index are cleared.
- Changes to `tx_data` or `tx_valid` after the accept edge have no effect on the frame in progress.
- Baud counter counts 0..CLKS_PER_BIT-1. The bit-end tick is asserted when count == CLKS_PER_BIT-1; the counter then wraps to 0. The counter width is `$clog2(CLKS_PER_BIT)`.
- DATA state:
  - `txd` = shift[0]; the shift register shifts right on each bit-end tick.
  - The 3-bit bit index increments on each bit-end tick.
  - The tick at bit index 7 ends DATA; the index wraps 7 -> 0.
- STOP state drives `txd` = 1. At the end of STOP:
  - `tx_ready` goes to 1 and `busy` to 0;
  - `txd` remains 1.
- `tx_valid` is ignored outside IDLE. There is no buffering, so a byte presented while busy waits for `tx_ready`.
- Reset values: state IDLE, `txd` = 1, `tx_ready` = 0, `busy` = 0, counters 0, shift register 0.
  - `tx_ready` rises on the first edge after `rst` is deasserted.
  - An accept is impossible while `rst` is high.
- Reset mid-frame aborts the frame. `txd` = 1 from the next edge; no partial stop bit is generated.
- Simultaneous `rst` and `tx_valid`: reset wins; the byte is not accepted.

## Timing
Let the accept edge be edge k and N = CLKS_PER_BIT.
- Start bit (`txd` = 0) is driven from edge k to edge k+N.
- Data bit i (i = 0..7) is driven from edge k+(1+i)·N to edge k+(2+i)·N.
- Stop bit (`txd` = 1) is driven from edge k+9N to edge k+10N.
- At edge k+10N: state IDLE, `tx_ready` = 1, `busy` = 0.
- The earliest next accept is edge k+10N+1. Back-to-back frames therefore have a period of 10N+1 cycles, including one idle-high cycle between frames.
- Latency from accept to the falling start edge on `txd`: 0 cycles (visible immediately after edge k).
- Every bit lasts exactly N cycles. There is no cumulative drift.

## Structure
- Shared package `serial_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, STOP);
  - `DEFAULT_CLKS_PER_BIT` = 868;
  - `UART_DATA_BITS` = 8.
- One sub-module: `baud_tick_gen`. It has parameter CLKS_PER_BIT and ports clk, rst, clear, tick. It implements the wrap counter and is reused by the receive path.
- The shift register, bit index and FSM live in `uart_tx`.

## Test plan
All scenarios use CLKS_PER_BIT = 4.
- Reset release: hold `rst` 3 cycles with `tx_valid` = 1 -> during reset `txd` = 1, `tx_ready` = 0, no frame. First edge after release: `tx_ready` = 1. Next edge: accept.
- Single byte 0xA5: accept at edge k -> `txd` per 4-cycle slot = 0, 1,0,1,0,0,1,0,1, 1. `tx_ready` = 1 at edge k+40.
- Back-to-back 0x00 then 0xFF with `tx_valid` held high -> second accept at edge k+41. `txd` is 1 for exactly one cycle between the two stop/start boundaries.
- Data hold: change `tx_data` to 0x3C one cycle after accepting 0x81 -> wire bits are 1,0,0,0,0,0,0,1 (0x81). `tx_valid` pulses while busy are ignored.
- Mid-frame reset: assert `rst` for 1 cycle at edge k+17 (data bit 3) -> `txd` = 1 from edge k+18, `busy` = 0. `tx_ready` = 1 at the following edge; a new 0x55 then transmits correctly.
- CLKS_PER_BIT = 2 corner: send 0x01 -> frame length 20 cycles, and each bit is exactly 2 cycles.
